// File: rtl/pe_mem_req_arbiter.sv
// PE SRAM front end: per-source request FIFOs for load/store and DMA, round-robin
// single-port issue, and read data returned to its source through a tag pipe.
module pe_mem_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_poweron,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         ready
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [AW:0]             count, count_nxt;
  logic                    do_push, do_pop;

  // ready is the start-of-cycle "not full", so a pop does not make room in the same cycle
  assign do_push   = push & ready;
  assign do_pop    = pop & not_empty;
  assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt != (AW+1)'(DEPTH));
    end
  end
endmodule

module pe_mem_req_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_wr,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_wr,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              idle
);
  localparam int NSRC = 2;  // index 0 = load/store, 1 = DMA
  localparam int L    = RD_LATENCY;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
  localparam int REQ_W = $bits(req_t);

  req_t [NSRC-1:0] in_req, head;
  logic [NSRC-1:0] in_valid, fifo_ready, ne, pop;
  req_t            granted;
  logic            grant_any, grant_src, last_dma, issue_src;
  logic [L-1:0]    tag_vld_pipe, tag_src_pipe;

  assign in_req[0]   = '{ls_req_wr, ls_req_addr, ls_req_wdata};
  assign in_req[1]   = '{dma_req_wr, dma_req_addr, dma_req_wdata};
  assign in_valid    = {dma_req_valid, ls_req_valid};
  assign ls_req_ready  = fifo_ready[0];
  assign dma_req_ready = fifo_ready[1];

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    pe_mem_req_fifo #(.W(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push          (in_valid[s]),
      .wdata         (in_req[s]),
      .pop           (pop[s]),
      .head          (head[s]),
      .not_empty     (ne[s]),
      .ready         (fifo_ready[s])
    );
  end

  // On a tie the source that did not win last time is granted
  always_comb begin
    grant_any = |ne;
    grant_src = ne[1];
    if (ne[0] && ne[1]) grant_src = ~last_dma;
  end
  assign pop     = {grant_any & grant_src, grant_any & ~grant_src};
  assign granted = head[grant_src];

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      issue_src     <= 1'b0;
      last_dma      <= 1'b1;
      tag_vld_pipe  <= '0;
      tag_src_pipe  <= '0;
      ls_rsp_valid  <= 1'b0;
      ls_rsp_data   <= '0;
      dma_rsp_valid <= 1'b0;
      dma_rsp_data  <= '0;
    end else begin
      mem_en <= grant_any;
      mem_we <= grant_any & granted.wr;
      if (grant_any) begin
        mem_addr  <= granted.addr;
        mem_wdata <= granted.wdata;
        issue_src <= grant_src;
        last_dma  <= grant_src;
      end
      // Tag pipe tracks the SRAM read latency so the tail lines up with mem_rdata
      tag_vld_pipe[0] <= mem_en & ~mem_we;
      tag_src_pipe[0] <= issue_src;
      for (int i = 1; i < L; i++) begin
        tag_vld_pipe[i] <= tag_vld_pipe[i-1];
        tag_src_pipe[i] <= tag_src_pipe[i-1];
      end
      ls_rsp_valid  <= tag_vld_pipe[L-1] & ~tag_src_pipe[L-1];
      dma_rsp_valid <= tag_vld_pipe[L-1] &  tag_src_pipe[L-1];
      if (tag_vld_pipe[L-1] && !tag_src_pipe[L-1]) ls_rsp_data  <= mem_rdata;
      if (tag_vld_pipe[L-1] &&  tag_src_pipe[L-1]) dma_rsp_data <= mem_rdata;
    end
  end

  assign idle = ~(|ne) & ~(|tag_vld_pipe) & ~mem_en;
endmodule

// File: tb/tb_pe_mem_req_arbiter.sv
// Directed bench for pe_mem_req_arbiter: per-cycle vector table plus sequences
// for arbitration, FIFO backpressure and reset during reads, against an SRAM model.
module tb_pe_mem_req_arbiter;
  localparam int ADDR_W = 24, DATA_W = 32, FIFO_DEPTH = 4, RD_LATENCY = 2;

  logic              clk = 1'b0, reset_poweron = 1'b1;
  logic              ls_req_valid = 1'b0, ls_req_ready, ls_req_wr = 1'b0;
  logic [ADDR_W-1:0] ls_req_addr = '0;
  logic [DATA_W-1:0] ls_req_wdata = '0;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              dma_req_valid = 1'b0, dma_req_ready, dma_req_wr = 1'b0;
  logic [ADDR_W-1:0] dma_req_addr = '0;
  logic [DATA_W-1:0] dma_req_wdata = '0;
  logic              dma_rsp_valid;
  logic [DATA_W-1:0] dma_rsp_data;
  logic              mem_en, mem_we, idle;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  pe_mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                       .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wr(ls_req_wr),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_wr(dma_req_wr),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .idle(idle)
  );

  always #5 clk = ~clk;

  // SRAM model: 256 words, preset to C0DE0000+addr, read data RD_LATENCY cycles after issue
  logic [DATA_W-1:0] sram [256];
  logic [RD_LATENCY-1:0][DATA_W-1:0] rd_pipe;
  initial for (int i = 0; i < 256; i++) sram[i] = 32'hC0DE_0000 + 32'(i);
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr[7:0]] : 32'h0;
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LATENCY-1];

  typedef logic [31:0] w_t;
  typedef struct {
    w_t lv, lw, la, ld, dv, dw, da, dd;
    w_t e_lrdy, e_drdy, e_en, e_we, e_addr, e_wdata;
    w_t e_lrv, e_lrd, e_drv, e_drd, e_idle;
  } vec_t;
  typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic we; logic [DATA_W-1:0] wdata; } iss_t;

  vec_t vt[14];
  iss_t iss_q[$], ls_iss[$], dma_iss[$];
  logic [DATA_W-1:0] ls_q[$], dma_q[$];
  int n_vec = 0, n_err = 0, cyc_n = 0;
  int li, di, liss, low_cnt;

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (mem_en) iss_q.push_back('{cyc_n, mem_addr, mem_we, mem_wdata});
    if (ls_rsp_valid) ls_q.push_back(ls_rsp_data);
    if (dma_rsp_valid) dma_q.push_back(dma_rsp_data);
  endtask

  task automatic clear_logs();
    iss_q.delete(); ls_q.delete(); dma_q.delete();
  endtask

  task automatic do_reset();
    ls_req_valid = 1'b0; dma_req_valid = 1'b0;
    reset_poweron = 1'b1;
    cyc(); cyc();
    reset_poweron = 1'b0;
  endtask

  initial begin
    //             lv lw la     ld            dv dw da     dd | lrdy drdy en we addr  wdata        lrv lrd           drv drd           idle
    vt[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            0, 0,            0, 0,            0};
    vt[1]  = '{1, 0, 32'h10, 0,            0, 0, 0,     0,  1, 1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0,            0, 0,            0};
    vt[2]  = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 1, 0, 32'h10, 0,            0, 0,            0, 0,            0};
    vt[3]  = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            0, 0,            0, 0,            0};
    vt[4]  = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            0, 0,            0, 0,            0};
    vt[5]  = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            1, 32'hDEADBEEF, 0, 0,            1};
    vt[6]  = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            0, 32'hDEADBEEF, 0, 0,            1};
    vt[7]  = '{1, 0, 32'h20, 0,            1, 0, 32'h30, 0, 1, 1, 0, 0, 0,     0,            0, 32'hDEADBEEF, 0, 0,            0};
    vt[8]  = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 1, 0, 32'h30, 0,            0, 32'hDEADBEEF, 0, 0,            0};
    vt[9]  = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 1, 0, 32'h20, 0,            0, 32'hDEADBEEF, 0, 0,            0};
    vt[10] = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            0, 32'hDEADBEEF, 0, 0,            0};
    vt[11] = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            0, 32'hDEADBEEF, 1, 32'hC0DE0030, 0};
    vt[12] = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            1, 32'hC0DE0020, 0, 32'hC0DE0030, 1};
    vt[13] = '{0, 0, 0,      0,            0, 0, 0,     0,  1, 1, 0, 0, 0,     0,            0, 32'hC0DE0020, 0, 32'hC0DE0030, 1};

    // Reset held for three cycles
    reset_poweron = 1'b1;
    repeat (3) cyc();
    chk("rst.ls_ready",  32'(ls_req_ready), 1);
    chk("rst.dma_ready", 32'(dma_req_ready), 1);
    chk("rst.idle",      32'(idle), 1);
    chk("rst.mem_en",    32'(mem_en), 0);
    chk("rst.ls_rsp",    32'(ls_rsp_valid), 0);
    chk("rst.dma_rsp",   32'(dma_rsp_valid), 0);
    reset_poweron = 1'b0;

    // Write-then-read on LS, then a DMA/LS read pair issued back to back
    for (int i = 0; i < 14; i++) begin
      ls_req_valid  = vt[i].lv[0]; ls_req_wr  = vt[i].lw[0];
      ls_req_addr   = vt[i].la[ADDR_W-1:0]; ls_req_wdata = vt[i].ld;
      dma_req_valid = vt[i].dv[0]; dma_req_wr = vt[i].dw[0];
      dma_req_addr  = vt[i].da[ADDR_W-1:0]; dma_req_wdata = vt[i].dd;
      cyc();
      chk($sformatf("v%0d.ls_ready", i),  32'(ls_req_ready),  vt[i].e_lrdy);
      chk($sformatf("v%0d.dma_ready", i), 32'(dma_req_ready), vt[i].e_drdy);
      chk($sformatf("v%0d.mem_en", i),    32'(mem_en),        vt[i].e_en);
      if (vt[i].e_en != 0) begin
        chk($sformatf("v%0d.mem_we", i),   32'(mem_we),   vt[i].e_we);
        chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), vt[i].e_addr);
        if (vt[i].e_we != 0) chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vt[i].e_wdata);
      end
      chk($sformatf("v%0d.ls_rsp_valid", i),  32'(ls_rsp_valid),  vt[i].e_lrv);
      chk($sformatf("v%0d.ls_rsp_data", i),   ls_rsp_data,        vt[i].e_lrd);
      chk($sformatf("v%0d.dma_rsp_valid", i), 32'(dma_rsp_valid), vt[i].e_drv);
      chk($sformatf("v%0d.dma_rsp_data", i),  dma_rsp_data,       vt[i].e_drd);
      chk($sformatf("v%0d.idle", i),          32'(idle),          vt[i].e_idle);
    end
    ls_req_valid = 1'b0; dma_req_valid = 1'b0;

    // Both sources push four reads back to back: LS-first alternation, 8 consecutive issues
    do_reset(); clear_logs();
    for (int i = 0; i < 4; i++) begin
      ls_req_valid = 1'b1; ls_req_wr = 1'b0; ls_req_addr = ADDR_W'(32'h40 + i);
      dma_req_valid = 1'b1; dma_req_wr = 1'b0; dma_req_addr = ADDR_W'(32'h50 + i);
      chk($sformatf("t3.ls_ready%0d", i),  32'(ls_req_ready), 1);
      chk($sformatf("t3.dma_ready%0d", i), 32'(dma_req_ready), 1);
      cyc();
    end
    ls_req_valid = 1'b0; dma_req_valid = 1'b0;
    repeat (12) cyc();
    chk("t3.n_issue", 32'(iss_q.size()), 8);
    for (int k = 0; k < 8 && k < iss_q.size(); k++) begin
      chk($sformatf("t3.addr%0d", k), 32'(iss_q[k].addr),
          (k % 2 == 0) ? 32'(32'h40 + k/2) : 32'(32'h50 + k/2));
      chk($sformatf("t3.cyc%0d", k), 32'(iss_q[k].cyc), 32'(iss_q[0].cyc + k));
    end
    chk("t3.n_ls_rsp", 32'(ls_q.size()), 4);
    chk("t3.n_dma_rsp", 32'(dma_q.size()), 4);
    for (int k = 0; k < 4 && k < ls_q.size(); k++)
      chk($sformatf("t3.ls_rsp%0d", k), ls_q[k], 32'hC0DE0040 + 32'(k));
    for (int k = 0; k < 4 && k < dma_q.size(); k++)
      chk($sformatf("t3.dma_rsp%0d", k), dma_q[k], 32'hC0DE0050 + 32'(k));

    // DMA keeps the port busy while LS streams writes until its FIFO fills
    do_reset(); clear_logs();
    li = 0; di = 0; liss = 0; low_cnt = 0;
    for (int c = 0; c < 200 && (li < 10 || di < 14); c++) begin
      ls_req_valid = (li < 10); ls_req_wr = 1'b1;
      ls_req_addr = ADDR_W'(32'h60 + li); ls_req_wdata = 32'h1000 + 32'(li);
      dma_req_valid = (di < 14); dma_req_wr = 1'b1;
      dma_req_addr = ADDR_W'(32'h80 + di); dma_req_wdata = 32'h2000 + 32'(di);
      chk($sformatf("t4.ls_ready_c%0d", c), 32'(ls_req_ready), 32'((li - liss) < FIFO_DEPTH));
      if (ls_req_valid && !ls_req_ready) low_cnt++;
      if (ls_req_valid && ls_req_ready) li++;
      if (dma_req_valid && dma_req_ready) di++;
      cyc();
      if (mem_en && mem_addr[7:4] == 4'h6) liss++;
    end
    ls_req_valid = 1'b0; dma_req_valid = 1'b0;
    chk("t4.all_accepted", 32'(li == 10 && di == 14), 1);
    chk("t4.ready_dropped", 32'(low_cnt != 0), 1);
    repeat (30) cyc();
    ls_iss.delete(); dma_iss.delete();
    foreach (iss_q[k]) begin
      if (iss_q[k].addr[7:4] == 4'h6) ls_iss.push_back(iss_q[k]);
      else dma_iss.push_back(iss_q[k]);
    end
    chk("t4.n_ls_issue", 32'(ls_iss.size()), 10);
    chk("t4.n_dma_issue", 32'(dma_iss.size()), 14);
    for (int k = 0; k < 10 && k < ls_iss.size(); k++) begin
      chk($sformatf("t4.ls_addr%0d", k),  32'(ls_iss[k].addr), 32'h60 + 32'(k));
      chk($sformatf("t4.ls_wdata%0d", k), ls_iss[k].wdata, 32'h1000 + 32'(k));
    end
    for (int k = 0; k < 14 && k < dma_iss.size(); k++)
      chk($sformatf("t4.dma_addr%0d", k), 32'(dma_iss[k].addr), 32'h80 + 32'(k));
    chk("t4.no_rsp", 32'(ls_q.size() + dma_q.size()), 0);

    // Reset one cycle after two reads issue discards both responses
    do_reset(); clear_logs();
    ls_req_valid = 1'b1; ls_req_wr = 1'b0; ls_req_addr = ADDR_W'(32'h44);
    dma_req_valid = 1'b1; dma_req_wr = 1'b0; dma_req_addr = ADDR_W'(32'h54);
    cyc();
    ls_req_valid = 1'b0; dma_req_valid = 1'b0;
    cyc(); cyc();
    chk("t5.n_issue", 32'(iss_q.size()), 2);
    reset_poweron = 1'b1;
    cyc();
    chk("t5.idle", 32'(idle), 1);
    chk("t5.mem_en", 32'(mem_en), 0);
    reset_poweron = 1'b0;
    repeat (6) cyc();
    chk("t5.no_ls_rsp", 32'(ls_q.size()), 0);
    chk("t5.no_dma_rsp", 32'(dma_q.size()), 0);
    chk("t5.idle_after", 32'(idle), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
